// File: rtl/shiftreg_ctrl_pkg.sv
// Shared definitions for the serial shift-register controller: state encodings,
// default word width and the counter sizing helper.
package shiftreg_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // The counter must reach WIDTH-1 while shifting and GAP-1 while idling out.
    function automatic int count_width(input int width, input int gap);
        int m;
        m = (width > gap + 1) ? width : gap + 1;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/shiftreg_n.sv
// Parameterised parallel-load / serial-shift register. Shifts toward the output
// end (MSB or LSB), filling from sin; q_next exposes the value about to be stored.
module shiftreg_n #(
    parameter int WIDTH     = 6,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             sin,
    output logic             sout,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] shifted;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign shifted[gi] = sin;
                end else begin : g_move
                    assign shifted[gi] = q_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign shifted[gi] = sin;
                end else begin : g_move
                    assign shifted[gi] = q_reg[gi+1];
                end
            end
        end
    endgenerate

    always_comb begin
        q_next = q_reg;
        if (load) begin
            q_next = load_data;
        end else if (shift_en) begin
            q_next = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign sout = MSB_FIRST ? q_reg[WIDTH-1] : q_reg[0];

endmodule

// File: rtl/shiftreg_ctrl.sv
// Load/shift/done sequencing for one serial frame: accepts a parallel word,
// shifts it out for WIDTH cycles while capturing the return stream, then idles.
module shiftreg_ctrl
    import shiftreg_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_en,
    input  logic             ser_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int CW = count_width(WIDTH, GAP);

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] out_data_reg;
    logic [WIDTH-1:0] rx_q_next;
    logic [WIDTH-1:0] tx_q_next_unused;
    logic             tx_sout;
    logic             rx_sout_unused;
    logic             accept;

    assign accept = (state_reg == ST_IDLE) && in_valid;

    shiftreg_n #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data (in_data),
        .shift_en  (ser_en),
        .sin       (1'b0),
        .sout      (tx_sout),
        .q_next    (tx_q_next_unused)
    );

    // The receive shifter is never loaded; WIDTH shifts fully replace its contents.
    shiftreg_n #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (ser_en),
        .sin       (ser_in),
        .sout      (rx_sout_unused),
        .q_next    (rx_q_next)
    );

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = ST_SHIFT;
                    count_next = '0;
                end
            end
            ST_SHIFT: begin
                if (count_reg == CW'(WIDTH - 1)) begin
                    state_next = ST_DONE;
                    count_next = '0;
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            ST_DONE: begin
                count_next = '0;
                state_next = (GAP > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (count_reg == CW'(GAP - 1)) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else begin
                    count_next = count_reg + CW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            // Capture includes the bit arriving on the final shift edge.
            if ((state_reg == ST_SHIFT) && (state_next == ST_DONE)) begin
                out_data_reg <= rx_q_next;
            end
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign ser_en    = (state_reg == ST_SHIFT);
    assign ser_out   = ser_en & tx_sout;
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign out_data  = out_data_reg;

endmodule
